// File: rtl/demux_handshake_router.sv
// Single-entry router: takes one word over a 4-phase dav/rfd handshake and
// delivers it to channel 0 or 1 over that channel's own 4-phase handshake.
module demux_handshake_router #(
    parameter int W  = 8,
    parameter int CW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [W-1:0]  in_data,
    input  logic          in_dest,
    input  logic          in_dav,
    output logic          in_rfd,
    output logic [W-1:0]  out_data0,
    output logic          out_dav0,
    input  logic          out_rfd0,
    output logic [W-1:0]  out_data1,
    output logic          out_dav1,
    input  logic          out_rfd1,
    output logic [CW-1:0] count0,
    output logic [CW-1:0] count1,
    output logic          busy
);

    typedef enum logic [2:0] {
        S_IN_WAIT,
        S_IN_REL,
        S_OUT_PRESENT,
        S_OUT_ACK,
        S_OUT_REL
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  buf_q, buf_d;
    logic          dest_q, dest_d;
    logic          in_rfd_q, in_rfd_d;
    logic          dav0_q, dav0_d;
    logic          dav1_q, dav1_d;
    logic [W-1:0]  data0_q, data0_d;
    logic [W-1:0]  data1_q, data1_d;
    logic [CW-1:0] cnt0_q, cnt0_d;
    logic [CW-1:0] cnt1_q, cnt1_d;
    logic          busy_q, busy_d;

    logic sel_rfd;
    logic sel_dav;

    // Only the addressed consumer's handshake is ever observed.
    assign sel_rfd = dest_q ? out_rfd1 : out_rfd0;
    assign sel_dav = dest_q ? dav1_q   : dav0_q;

    always_comb begin
        // NOTE: every next-state value defaults to its current value first, so
        // no path through the case leaves a signal unassigned (no latches).
        state_d  = state_q;
        buf_d    = buf_q;
        dest_d   = dest_q;
        in_rfd_d = in_rfd_q;
        dav0_d   = dav0_q;
        dav1_d   = dav1_q;
        data0_d  = data0_q;
        data1_d  = data1_q;
        cnt0_d   = cnt0_q;
        cnt1_d   = cnt1_q;

        unique case (state_q)
            S_IN_WAIT: begin
                if (in_dav) begin
                    buf_d    = in_data;
                    dest_d   = in_dest;
                    in_rfd_d = 1'b0;
                    state_d  = S_IN_REL;
                end
            end
            S_IN_REL: begin
                if (!in_dav) state_d = S_OUT_PRESENT;
            end
            S_OUT_PRESENT: begin
                if (dest_q) data1_d = buf_q;
                else        data0_d = buf_q;
                state_d = S_OUT_ACK;
            end
            S_OUT_ACK: begin
                // dav rises only once the consumer shows rfd, a cycle after data.
                if (!sel_dav) begin
                    if (sel_rfd) begin
                        if (dest_q) dav1_d = 1'b1;
                        else        dav0_d = 1'b1;
                    end
                end else if (!sel_rfd) begin
                    if (dest_q) begin
                        dav1_d = 1'b0;
                        cnt1_d = cnt1_q + 1'b1;
                    end else begin
                        dav0_d = 1'b0;
                        cnt0_d = cnt0_q + 1'b1;
                    end
                    state_d = S_OUT_REL;
                end
            end
            S_OUT_REL: begin
                if (sel_rfd) begin
                    in_rfd_d = 1'b1;
                    state_d  = S_IN_WAIT;
                end
            end
            default: state_d = S_IN_WAIT;
        endcase

        busy_d = (state_d != S_IN_WAIT);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IN_WAIT;
            buf_q    <= '0;
            dest_q   <= 1'b0;
            in_rfd_q <= 1'b1;
            dav0_q   <= 1'b0;
            dav1_q   <= 1'b0;
            data0_q  <= '0;
            data1_q  <= '0;
            cnt0_q   <= '0;
            cnt1_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            dest_q   <= dest_d;
            in_rfd_q <= in_rfd_d;
            dav0_q   <= dav0_d;
            dav1_q   <= dav1_d;
            data0_q  <= data0_d;
            data1_q  <= data1_d;
            cnt0_q   <= cnt0_d;
            cnt1_q   <= cnt1_d;
            busy_q   <= busy_d;
        end
    end

    assign in_rfd    = in_rfd_q;
    assign out_data0 = data0_q;
    assign out_dav0  = dav0_q;
    assign out_data1 = data1_q;
    assign out_dav1  = dav1_q;
    assign count0    = cnt0_q;
    assign count1    = cnt1_q;
    assign busy      = busy_q;

endmodule
